vx_ti_trav_ctrl: RTL and testbench

// Sequencer for one BVH traversal engine in the ti (triangle-intersect) unit. Accepts one ray plus a root

---
 rtl/vx_ti_trav_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vx_ti_trav_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ti_trav_ctrl.sv
// BVH traversal sequencer for one ti engine. It walks the tree depth-first using an index stack,
// sends inner nodes to the AABB tester and leaves to the triangle tester, and keeps the closest hit.
module vx_ti_trav_ctrl #(
   parameter int                STACK_DEPTH = 16,
   parameter int                IDX_W       = 32,
   parameter int                ADDR_W      = 32,
   parameter int                RAY_W       = 256,
   parameter logic [ADDR_W-1:0] NODE_BASE   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [RAY_W-1:0]  req_ray,
   input  logic [IDX_W-1:0]  req_root,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [255:0]      mem_rsp_data,
   output logic              aabb_valid,
   input  logic              aabb_ready,
   output logic [RAY_W-1:0]  aabb_ray,
   output logic [255:0]      aabb_node,
   input  logic              aabb_rsp_valid,
   input  logic [1:0]        aabb_rsp_hit,
   output logic              tri_valid,
   input  logic              tri_ready,
   output logic [RAY_W-1:0]  tri_ray,
   output logic [IDX_W-1:0]  tri_idx,
   input  logic              tri_rsp_valid,
   input  logic              tri_rsp_hit,
   input  logic [31:0]       tri_rsp_t,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_hit,
   output logic [IDX_W-1:0]  rsp_tri_idx,
   output logic [31:0]       rsp_t,
   output logic              rsp_overflow
);
   localparam int          SP_W  = $clog2(STACK_DEPTH) + 1;
   localparam int          SL_W  = SP_W - 1;
   localparam logic [31:0] T_INF = 32'h7F80_0000;

   typedef enum logic [3:0] {IDLE, POP, FETCH, FWAIT, AABB, AWAIT, TRI, TWAIT, DONE} state_t;
   state_t state, state_nx;

   logic [IDX_W-1:0] stack [STACK_DEPTH];
   logic [SP_W-1:0]  sp, free, push_n;
   logic [SL_W-1:0]  sp_lo, top, wr0_slot, wr1_slot;
   logic [IDX_W-1:0] wr0_data, wr1_data;
   logic             wr0_en, wr1_en, drop;
   logic [RAY_W-1:0] ray;
   logic [255:0]     node;
   logic [IDX_W-1:0] cur_idx, best_idx, child0, child1;
   logic [31:0]      best_t;
   logic             hit, overflow;
   logic             accept, pop, push_evt, tri_upd;

   assign sp_lo    = sp[SL_W-1:0];
   assign top      = sp_lo - 1'b1;
   assign free     = SP_W'(STACK_DEPTH) - sp;
   assign child0   = node[IDX_W-1:0];
   assign child1   = node[32 +: IDX_W];
   assign accept   = (state == IDLE) && req_valid;
   assign pop      = (state == POP) && (sp != '0);
   assign push_evt = (state == AWAIT) && aabb_rsp_valid;
   // unsigned compare orders non-negative fp32 correctly; a tie keeps the earlier hit
   assign tri_upd  = (state == TWAIT) && tri_rsp_valid && tri_rsp_hit && (tri_rsp_t < best_t);

   always_comb begin
      wr0_en   = 1'b0;
      wr0_slot = sp_lo;
      wr0_data = child1;
      wr1_en   = 1'b0;
      wr1_slot = sp_lo + 1'b1;
      wr1_data = child0;
      push_n   = '0;
      drop     = 1'b0;
      if (accept) begin
         wr0_en   = 1'b1;
         wr0_slot = '0;
         wr0_data = req_root;
      end else if (push_evt) begin
         case (aabb_rsp_hit)
            2'b11: begin
               // child1 is written first so child0 lands on top; with one slot left child0 is lost
               if (free >= SP_W'(2)) begin
                  wr0_en = 1'b1;
                  wr1_en = 1'b1;
                  push_n = SP_W'(2);
               end else if (free == SP_W'(1)) begin
                  wr0_en = 1'b1;
                  push_n = SP_W'(1);
                  drop   = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
            2'b10, 2'b01: begin
               wr0_data = aabb_rsp_hit[1] ? child1 : child0;
               if (free != '0) begin
                  wr0_en = 1'b1;
                  push_n = SP_W'(1);
               end else begin
                  drop = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr0_en) stack[wr0_slot] <= wr0_data;
      if (wr1_en) stack[wr1_slot] <= wr1_data;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = POP;
         POP:     state_nx = (sp == '0) ? DONE : FETCH;
         FETCH:   if (mem_req_ready) state_nx = FWAIT;
         FWAIT:   if (mem_rsp_valid) state_nx = mem_rsp_data[255] ? TRI : AABB;
         AABB:    if (aabb_ready) state_nx = AWAIT;
         AWAIT:   if (aabb_rsp_valid) state_nx = POP;
         TRI:     if (tri_ready) state_nx = TWAIT;
         TWAIT:   if (tri_rsp_valid) state_nx = POP;
         DONE:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp       <= '0;
         ray      <= '0;
         node     <= '0;
         cur_idx  <= '0;
         best_t   <= T_INF;
         best_idx <= '0;
         hit      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            sp       <= SP_W'(1);
            ray      <= req_ray;
            best_t   <= T_INF;
            best_idx <= '0;
            hit      <= 1'b0;
            overflow <= 1'b0;
         end else begin
            sp <= sp + push_n - SP_W'(pop);
         end
         if (pop) cur_idx <= stack[top];
         if (drop) overflow <= 1'b1;
         if (state == FWAIT && mem_rsp_valid) node <= mem_rsp_data;
         if (tri_upd) begin
            best_t   <= tri_rsp_t;
            best_idx <= child0;
            hit      <= 1'b1;
         end
      end
   end

   always_comb begin
      req_ready     = (state == IDLE);
      mem_req_valid = (state == FETCH);
      aabb_valid    = (state == AABB);
      tri_valid     = (state == TRI);
      rsp_valid     = (state == DONE);
      mem_req_addr  = NODE_BASE + ADDR_W'({cur_idx, 5'b0});
      aabb_ray      = ray;
      aabb_node     = node;
      tri_ray       = ray;
      tri_idx       = child0;
      rsp_hit       = 1'b0;
      rsp_tri_idx   = '0;
      rsp_t         = '0;
      rsp_overflow  = 1'b0;
      if (state == DONE) begin
         rsp_hit      = hit;
         rsp_tri_idx  = hit ? best_idx : '0;
         rsp_t        = best_t;
         rsp_overflow = overflow;
      end
   end
endmodule

// File: tb/tb_vx_ti_trav_ctrl.sv
// Directed bench for vx_ti_trav_ctrl: a vector table of small trees plus reset/stall sequences.
module tb_vx_ti_trav_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, sel;
   logic         req_valid_a, req_valid_b;
   logic [255:0] req_ray;
   logic [31:0]  req_root;
   logic         mem_req_ready, mem_rsp_valid;
   logic [255:0] mem_rsp_data;
   logic         aabb_ready, aabb_rsp_valid;
   logic [1:0]   aabb_rsp_hit;
   logic         tri_ready, tri_rsp_valid, tri_rsp_hit;
   logic [31:0]  tri_rsp_t;
   logic         rsp_ready;

   logic [1:0]   req_ready_i, mem_req_valid_i, aabb_valid_i, tri_valid_i;
   logic [1:0]   rsp_valid_i, rsp_hit_i, rsp_overflow_i;
   logic [31:0]  mem_req_addr_i [2];
   logic [255:0] aabb_ray_i [2];
   logic [255:0] aabb_node_i [2];
   logic [255:0] tri_ray_i [2];
   logic [31:0]  tri_idx_i [2];
   logic [31:0]  rsp_tri_idx_i [2];
   logic [31:0]  rsp_t_i [2];

   wire          req_ready     = req_ready_i[sel];
   wire          mem_req_valid = mem_req_valid_i[sel];
   wire          aabb_valid    = aabb_valid_i[sel];
   wire          tri_valid     = tri_valid_i[sel];
   wire          rsp_valid     = rsp_valid_i[sel];
   wire          rsp_hit       = rsp_hit_i[sel];
   wire          rsp_overflow  = rsp_overflow_i[sel];
   wire [31:0]   mem_req_addr  = mem_req_addr_i[sel];
   wire [255:0]  aabb_ray      = aabb_ray_i[sel];
   wire [255:0]  aabb_node     = aabb_node_i[sel];
   wire [255:0]  tri_ray       = tri_ray_i[sel];
   wire [31:0]   tri_idx       = tri_idx_i[sel];
   wire [31:0]   rsp_tri_idx   = rsp_tri_idx_i[sel];
   wire [31:0]   rsp_t         = rsp_t_i[sel];

   vx_ti_trav_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(req_ready_i[0]), .req_ray(req_ray), .req_root(req_root),
      .mem_req_valid(mem_req_valid_i[0]), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr_i[0]),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .aabb_valid(aabb_valid_i[0]), .aabb_ready(aabb_ready), .aabb_ray(aabb_ray_i[0]), .aabb_node(aabb_node_i[0]),
      .aabb_rsp_valid(aabb_rsp_valid), .aabb_rsp_hit(aabb_rsp_hit),
      .tri_valid(tri_valid_i[0]), .tri_ready(tri_ready), .tri_ray(tri_ray_i[0]), .tri_idx(tri_idx_i[0]),
      .tri_rsp_valid(tri_rsp_valid), .tri_rsp_hit(tri_rsp_hit), .tri_rsp_t(tri_rsp_t),
      .rsp_valid(rsp_valid_i[0]), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit_i[0]),
      .rsp_tri_idx(rsp_tri_idx_i[0]), .rsp_t(rsp_t_i[0]), .rsp_overflow(rsp_overflow_i[0])
   );

   vx_ti_trav_ctrl #(.STACK_DEPTH(2)) dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(req_ready_i[1]), .req_ray(req_ray), .req_root(req_root),
      .mem_req_valid(mem_req_valid_i[1]), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr_i[1]),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .aabb_valid(aabb_valid_i[1]), .aabb_ready(aabb_ready), .aabb_ray(aabb_ray_i[1]), .aabb_node(aabb_node_i[1]),
      .aabb_rsp_valid(aabb_rsp_valid), .aabb_rsp_hit(aabb_rsp_hit),
      .tri_valid(tri_valid_i[1]), .tri_ready(tri_ready), .tri_ray(tri_ray_i[1]), .tri_idx(tri_idx_i[1]),
      .tri_rsp_valid(tri_rsp_valid), .tri_rsp_hit(tri_rsp_hit), .tri_rsp_t(tri_rsp_t),
      .rsp_valid(rsp_valid_i[1]), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit_i[1]),
      .rsp_tri_idx(rsp_tri_idx_i[1]), .rsp_t(rsp_t_i[1]), .rsp_overflow(rsp_overflow_i[1])
   );

   typedef struct {
      int          root;
      bit          sel;
      bit          stall;
      int          lat;
      int          nf;
      int          f0, f1, f2, f3;
      int          ntri;
      bit          hit;
      logic [31:0] idx;
      logic [31:0] t;
      bit          ovf;
   } vec_t;

   logic [255:0] nodes [32];
   logic [1:0]   aabb_tab [32];
   logic         tri_hit_tab [32];
   logic [31:0]  tri_t_tab [32];
   vec_t         vecs [10];
   int           total = 0, bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_node(input bit leaf, input int c0, input int c1, input int tag);
      logic [255:0] n;
      n          = '0;
      n[255]     = leaf;
      n[31:0]    = 32'(c0);
      n[63:32]   = 32'(c1);
      n[127:96]  = 32'hA500_0000 | 32'(tag);
      return n;
   endfunction

   task automatic set_leaf(input int n, input int tri_id, input bit h, input logic [31:0] t);
      nodes[n]           = mk_node(1'b1, tri_id, 0, n);
      tri_hit_tab[tri_id] = h;
      tri_t_tab[tri_id]   = t;
   endtask

   task automatic set_inner(input int n, input int c0, input int c1, input logic [1:0] h);
      nodes[n]    = mk_node(1'b0, c0, c1, n);
      aabb_tab[n] = h;
   endtask

   // Plays memory and both testers with one-cycle responses; optional 5-cycle ready stalls.
   task automatic run_ray(input int n, input vec_t v);
      logic [255:0] ray, a_node_h, a_ray_h, t_ray_h;
      logic [31:0]  m_addr_h, t_idx_h, r_idx, r_t;
      logic [1:0]   aabb_p;
      logic         r_hit, r_ovf;
      int           fq[$];
      int           fe[4];
      int           ntri, lat, cyc, ms, as_c, ts, rs, mem_pidx, tri_pidx, last, idx;
      bit           mem_pend, aabb_pend, tri_pend, done, got, m_st, a_st, t_st;
      ntri = 0; lat = -1; cyc = 0; mem_pidx = 0; tri_pidx = 0; last = 0;
      mem_pend = 0; aabb_pend = 0; tri_pend = 0; done = 0; got = 0; m_st = 0; a_st = 0; t_st = 0;
      r_hit = 0; r_ovf = 0; r_idx = '0; r_t = '0; aabb_p = '0;
      m_addr_h = '0; t_idx_h = '0; a_node_h = '0; a_ray_h = '0; t_ray_h = '0;
      ms = v.stall ? 5 : 0; as_c = ms; ts = ms; rs = ms;
      ray = {8{32'h1000_0000 + 32'(n)}};
      sel = v.sel;
      @(negedge clk);
      chk($sformatf("v%0d.idle_ready", n), 256'(req_ready), 256'(1));
      req_ray  = ray;
      req_root = 32'(v.root);
      if (v.sel) req_valid_b = 1'b1;
      else       req_valid_a = 1'b1;
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_ray     = ~ray;
      req_root    = '1;
      while (!done && cyc < 300) begin
         mem_rsp_valid  = mem_pend;
         mem_rsp_data   = mem_pend ? nodes[mem_pidx] : '0;
         aabb_rsp_valid = aabb_pend;
         aabb_rsp_hit   = aabb_pend ? aabb_p : 2'b00;
         tri_rsp_valid  = tri_pend;
         tri_rsp_hit    = tri_pend ? tri_hit_tab[tri_pidx] : 1'b0;
         tri_rsp_t      = tri_pend ? tri_t_tab[tri_pidx] : '0;
         mem_pend = 0; aabb_pend = 0; tri_pend = 0;
         mem_req_ready = 1'b0; aabb_ready = 1'b0; tri_ready = 1'b0; rsp_ready = 1'b0;

         if (mem_req_valid) begin
            if (!m_st) begin m_st = 1; m_addr_h = mem_req_addr; end
            else chk($sformatf("v%0d.mem_addr_stable", n), 256'(mem_req_addr), 256'(m_addr_h));
            if (ms > 0) ms--;
            else begin
               mem_req_ready = 1'b1;
               m_st = 0;
               idx = int'(mem_req_addr >> 5);
               fq.push_back(idx);
               mem_pidx = (idx < 32) ? idx : 31;
               last = mem_pidx;
               mem_pend = 1;
            end
         end else if (m_st) chk($sformatf("v%0d.mem_valid_held", n), 256'(mem_req_valid), 256'(1));

         if (aabb_valid) begin
            if (!a_st) begin
               a_st = 1; a_node_h = aabb_node; a_ray_h = aabb_ray;
               chk($sformatf("v%0d.aabb_node", n), aabb_node, nodes[last]);
               chk($sformatf("v%0d.aabb_ray", n), aabb_ray, ray);
            end else begin
               chk($sformatf("v%0d.aabb_node_stable", n), aabb_node, a_node_h);
               chk($sformatf("v%0d.aabb_ray_stable", n), aabb_ray, a_ray_h);
            end
            if (as_c > 0) as_c--;
            else begin aabb_ready = 1'b1; a_st = 0; aabb_pend = 1; aabb_p = aabb_tab[last]; end
         end else if (a_st) chk($sformatf("v%0d.aabb_valid_held", n), 256'(aabb_valid), 256'(1));

         if (tri_valid) begin
            if (!t_st) begin
               t_st = 1; t_idx_h = tri_idx; t_ray_h = tri_ray;
               chk($sformatf("v%0d.tri_idx", n), 256'(tri_idx), 256'(nodes[last][31:0]));
               chk($sformatf("v%0d.tri_ray", n), tri_ray, ray);
            end else begin
               chk($sformatf("v%0d.tri_idx_stable", n), 256'(tri_idx), 256'(t_idx_h));
               chk($sformatf("v%0d.tri_ray_stable", n), tri_ray, t_ray_h);
            end
            if (ts > 0) ts--;
            else begin
               tri_ready = 1'b1; t_st = 0; tri_pend = 1; ntri++;
               tri_pidx = (tri_idx < 32) ? int'(tri_idx) : 31;
            end
         end else if (t_st) chk($sformatf("v%0d.tri_valid_held", n), 256'(tri_valid), 256'(1));

         if (rsp_valid) begin
            if (!got) begin
               got = 1; lat = cyc;
               r_hit = rsp_hit; r_idx = rsp_tri_idx; r_t = rsp_t; r_ovf = rsp_overflow;
            end else begin
               chk($sformatf("v%0d.rsp_t_stable", n), 256'(rsp_t), 256'(r_t));
               chk($sformatf("v%0d.rsp_idx_stable", n), 256'(rsp_tri_idx), 256'(r_idx));
            end
            if (rs > 0) rs--;
            else begin rsp_ready = 1'b1; done = 1; end
         end
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b0; mem_rsp_valid = 1'b0; aabb_rsp_valid = 1'b0; tri_rsp_valid = 1'b0;
      chk($sformatf("v%0d.completed", n), 256'(done), 256'(1));
      chk($sformatf("v%0d.ready_after", n), 256'(req_ready), 256'(1));
      chk($sformatf("v%0d.rsp_dropped", n), 256'(rsp_valid), 256'(0));
      chk($sformatf("v%0d.hit", n), 256'(r_hit), 256'(v.hit));
      chk($sformatf("v%0d.idx", n), 256'(r_idx), 256'(v.idx));
      chk($sformatf("v%0d.t", n), 256'(r_t), 256'(v.t));
      chk($sformatf("v%0d.ovf", n), 256'(r_ovf), 256'(v.ovf));
      chk($sformatf("v%0d.ntri", n), 256'(ntri), 256'(v.ntri));
      chk($sformatf("v%0d.nfetch", n), 256'(fq.size()), 256'(v.nf));
      fe = '{v.f0, v.f1, v.f2, v.f3};
      if (fq.size() == v.nf)
         for (int i = 0; i < v.nf; i++)
            chk($sformatf("v%0d.fetch%0d", n, i), 256'(fq[i]), 256'(fe[i]));
      if (v.lat != 0) chk($sformatf("v%0d.latency", n), 256'(lat), 256'(v.lat));
   endtask

   initial begin
      bit mp, seen;
      reset = 1'b1; sel = 1'b0;
      req_valid_a = 1'b0; req_valid_b = 1'b0; req_ray = '0; req_root = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      aabb_ready = 1'b0; aabb_rsp_valid = 1'b0; aabb_rsp_hit = '0;
      tri_ready = 1'b0; tri_rsp_valid = 1'b0; tri_rsp_hit = 1'b0; tri_rsp_t = '0; rsp_ready = 1'b0;

      for (int i = 0; i < 32; i++) begin
         nodes[i] = '0; aabb_tab[i] = 2'b00; tri_hit_tab[i] = 1'b0; tri_t_tab[i] = 32'h0000_0001;
      end
      set_leaf(0, 7, 1'b1, 32'h3F80_0000);
      set_inner(1, 2, 3, 2'b11);
      set_leaf(2, 3, 1'b1, 32'h4000_0000);
      set_leaf(3, 4, 1'b1, 32'h3F00_0000);
      set_inner(4, 5, 6, 2'b00);
      set_leaf(5, 1, 1'b1, 32'h0000_0010);
      set_leaf(6, 2, 1'b1, 32'h0000_0010);
      set_inner(7, 8, 9, 2'b11);
      set_leaf(8, 11, 1'b1, 32'h3F80_0000);
      set_leaf(9, 12, 1'b1, 32'h3F80_0000);
      set_inner(10, 11, 12, 2'b01);
      set_leaf(11, 13, 1'b1, 32'h4100_0000);
      set_leaf(12, 14, 1'b1, 32'h0000_0001);
      set_inner(13, 14, 15, 2'b10);
      set_leaf(14, 15, 1'b1, 32'h0000_0001);
      set_leaf(15, 16, 1'b1, 32'h40A0_0000);
      set_leaf(16, 17, 1'b0, 32'h3E00_0000);
      set_inner(20, 21, 22, 2'b11);
      set_inner(21, 23, 24, 2'b11);
      set_leaf(22, 10, 1'b0, 32'h0000_0001);
      set_leaf(23, 18, 1'b1, 32'h0000_0001);
      set_leaf(24, 9, 1'b1, 32'h4040_0000);

      //          root sel   stall lat nf  fetch list     ntri hit   idx     t              ovf
      vecs[0] = '{0,  1'b0, 1'b0, 6, 1, 0, 0, 0, 0,    1, 1'b1, 32'd7,  32'h3F80_0000, 1'b0};
      vecs[1] = '{1,  1'b0, 1'b0, 0, 3, 1, 2, 3, 0,    2, 1'b1, 32'd4,  32'h3F00_0000, 1'b0};
      vecs[2] = '{4,  1'b0, 1'b0, 0, 1, 4, 0, 0, 0,    0, 1'b0, 32'd0,  32'h7F80_0000, 1'b0};
      vecs[3] = '{7,  1'b0, 1'b0, 0, 3, 7, 8, 9, 0,    2, 1'b1, 32'd11, 32'h3F80_0000, 1'b0};
      vecs[4] = '{10, 1'b0, 1'b0, 0, 2, 10, 11, 0, 0,  1, 1'b1, 32'd13, 32'h4100_0000, 1'b0};
      vecs[5] = '{13, 1'b0, 1'b0, 0, 2, 13, 15, 0, 0,  1, 1'b1, 32'd16, 32'h40A0_0000, 1'b0};
      vecs[6] = '{16, 1'b0, 1'b0, 0, 1, 16, 0, 0, 0,   1, 1'b0, 32'd0,  32'h7F80_0000, 1'b0};
      vecs[7] = '{20, 1'b1, 1'b0, 0, 4, 20, 21, 24, 22, 2, 1'b1, 32'd9, 32'h4040_0000, 1'b1};
      vecs[8] = '{1,  1'b0, 1'b1, 0, 3, 1, 2, 3, 0,    2, 1'b1, 32'd4,  32'h3F00_0000, 1'b0};
      vecs[9] = '{0,  1'b1, 1'b0, 6, 1, 0, 0, 0, 0,    1, 1'b1, 32'd7,  32'h3F80_0000, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst.req_ready", 256'(req_ready_i), 256'(2'b11));
      chk("rst.rsp_valid", 256'(rsp_valid_i), 256'(0));
      chk("rst.mem_req_valid", 256'(mem_req_valid_i), 256'(0));
      chk("rst.tester_valids", 256'({aabb_valid_i, tri_valid_i}), 256'(0));
      chk("rst.rsp_fields", 256'({rsp_hit, rsp_overflow, rsp_t, rsp_tri_idx}), 256'(0));
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_ray(i, vecs[i]);

      // abort a ray while it waits on the AABB tester, then feed it a stale result
      sel = 1'b0; mp = 0; seen = 0;
      @(negedge clk);
      req_ray = {8{32'hDEAD_0001}}; req_root = 32'd1; req_valid_a = 1'b1;
      @(negedge clk);
      req_valid_a = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         mem_rsp_valid = mp; mem_rsp_data = nodes[1]; mp = 0;
         mem_req_ready = 1'b1; aabb_ready = 1'b1;
         if (mem_req_valid) mp = 1;
         if (aabb_valid) seen = 1;
         @(negedge clk);
      end
      chk("abort.reached_await", 256'(seen), 256'(1));
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; aabb_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.req_ready", 256'(req_ready), 256'(1));
      chk("abort.rsp_valid", 256'(rsp_valid), 256'(0));
      chk("abort.mem_req_valid", 256'(mem_req_valid), 256'(0));
      aabb_rsp_valid = 1'b1; aabb_rsp_hit = 2'b11;
      @(negedge clk);
      aabb_rsp_valid = 1'b0; aabb_rsp_hit = 2'b00;
      chk("abort.stale_ignored", 256'({req_ready, mem_req_valid, aabb_valid}), 256'(3'b100));
      run_ray(10, vecs[1]);
      run_ray(11, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
